// File: rtl/compass_sequencer.sv
// compass_sequencer: schedules magnetometer reads, reduces |X|,|Y| to a clamped
// octant ratio by repeated subtraction, and folds the atan ROM angle into a heading.
module compass_sequencer #(
    parameter int SAMPLE_PERIOD = 1000000,
    parameter int GO_WIDTH      = 100,
    parameter int RD_TIMEOUT    = 2000000
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        enable,
    input  logic        sample_now,
    output logic        go,
    input  logic        rd_done,
    input  logic [15:0] x_data,
    input  logic [15:0] y_data,
    output logic [7:0]  rom_addr,
    input  logic [7:0]  rom_data,
    output logic [9:0]  heading,
    output logic        heading_valid,
    output logic        busy,
    output logic        timeout_err
);

    localparam int PW   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int TMAX = (RD_TIMEOUT > GO_WIDTH) ? RD_TIMEOUT : GO_WIDTH;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [TW-1:0] GO_LAST     = TW'(GO_WIDTH - 1);
    localparam logic [TW-1:0] RD_LIMIT    = TW'(RD_TIMEOUT);
    localparam logic [3:0]    Q_MAX       = 4'd9;
    localparam logic [7:0]    ADDR_MID    = 8'd9;

    typedef enum logic [2:0] {
        IDLE, GO, WAIT_RD, LATCH, DIVIDE, ROM_ADDR, ROM_WAIT, OUTPUT
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] period_q, period_d;
    logic          pending_q, pending_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   x_q, x_d, y_q, y_d;
    logic [14:0]   rem_q, rem_d, small_q, small_d;
    logic [3:0]    quot_q, quot_d;
    logic [1:0]    quad_q, quad_d;
    logic          ymaj_q, ymaj_d, equal_q, equal_d;
    logic [7:0]    rom_addr_q, rom_addr_d;
    logic [9:0]    heading_q, heading_d;

    logic [14:0]   ax, ay, bigAbs, smallAbs;
    logic [9:0]    angle, folded;
    logic          wrap;

    function automatic logic [14:0] absSat(input logic [15:0] v);
        logic [15:0] neg;
        neg = 16'd0 - v;
        if (!v[15])             return v[14:0];
        else if (v == 16'h8000) return 15'h7fff;
        else                    return neg[14:0];
    endfunction

    assign ax       = absSat(x_q);
    assign ay       = absSat(y_q);
    assign bigAbs   = (ax > ay) ? ax : ay;
    assign smallAbs = (ax > ay) ? ay : ax;
    assign wrap     = enable && (period_q == PERIOD_LAST);

    // Quadrant fold of the first-quadrant ROM angle; 360 wraps back to north.
    always_comb begin
        angle  = {2'b00, rom_data};
        folded = angle;
        case (quad_q)
            2'd1:    folded = 10'd180 - angle;
            2'd2:    folded = 10'd180 + angle;
            2'd3:    folded = (angle == 10'd0) ? 10'd0 : 10'd360 - angle;
            default: folded = angle;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        timer_d       = timer_q;
        x_d           = x_q;
        y_d           = y_q;
        rem_d         = rem_q;
        small_d       = small_q;
        quot_d        = quot_q;
        quad_d        = quad_q;
        ymaj_d        = ymaj_q;
        equal_d       = equal_q;
        rom_addr_d    = rom_addr_q;
        heading_d     = heading_q;
        go            = 1'b0;
        heading_valid = 1'b0;
        timeout_err   = 1'b0;
        period_d      = (enable && !wrap) ? period_q + 1'b1 : '0;

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    timer_d   = '0;
                    state_d   = GO;
                end
            end
            GO: begin
                go = 1'b1;
                if (timer_q == GO_LAST) begin
                    timer_d = '0;
                    state_d = WAIT_RD;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_RD: begin
                if (rd_done) begin
                    x_d     = x_data;
                    y_d     = y_data;
                    state_d = LATCH;
                end else if (timer_q == RD_LIMIT) begin
                    timeout_err = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            LATCH: begin
                rem_d   = bigAbs;
                small_d = smallAbs;
                ymaj_d  = ay > ax;
                equal_d = ax == ay;
                quad_d  = {y_q[15], x_q[15] ^ y_q[15]};
                quot_d  = (smallAbs == 15'd0) ? Q_MAX : 4'd0;
                state_d = DIVIDE;
            end
            // Ratio is clamped at 9, so the subtraction loop never runs away on small=0.
            DIVIDE: begin
                if (quot_q < Q_MAX && rem_q >= small_q) begin
                    rem_d  = rem_q - small_q;
                    quot_d = quot_q + 4'd1;
                end else begin
                    if (equal_q)     rom_addr_d = ADDR_MID;
                    else if (ymaj_q) rom_addr_d = ADDR_MID + {4'd0, quot_q};
                    else             rom_addr_d = ADDR_MID - {4'd0, quot_q};
                    state_d = ROM_ADDR;
                end
            end
            ROM_ADDR: state_d = ROM_WAIT;
            ROM_WAIT: state_d = OUTPUT;
            OUTPUT: begin
                heading_valid = 1'b1;
                heading_d     = folded;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (sample_now || wrap) pending_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= IDLE;
            period_q   <= '0;
            pending_q  <= 1'b0;
            timer_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            rem_q      <= '0;
            small_q    <= '0;
            quot_q     <= '0;
            quad_q     <= '0;
            ymaj_q     <= 1'b0;
            equal_q    <= 1'b0;
            rom_addr_q <= '0;
            heading_q  <= '0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            pending_q  <= pending_d;
            timer_q    <= timer_d;
            x_q        <= x_d;
            y_q        <= y_d;
            rem_q      <= rem_d;
            small_q    <= small_d;
            quot_q     <= quot_d;
            quad_q     <= quad_d;
            ymaj_q     <= ymaj_d;
            equal_q    <= equal_d;
            rom_addr_q <= rom_addr_d;
            heading_q  <= heading_d;
        end
    end

    // The new heading is shown during OUTPUT so it coincides with heading_valid.
    assign heading  = (state_q == OUTPUT) ? folded : heading_q;
    assign rom_addr = rom_addr_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: doc/compass_sequencer.md
COMPASS_SEQUENCER -- requirements
Module: compass_sequencer

Interface
REQ-001 SHALL have parameter SAMPLE_PERIOD, default 1000000, clock cycles between automatic sensor reads.
REQ-002 SHALL have parameter GO_WIDTH, default 100, cycles that go is held high per read request.
REQ-003 SHALL have parameter RD_TIMEOUT, default 2000000, max cycles to wait for rd_done after go falls.
REQ-004 SHALL have ports:
  clk  in  1  system clock; all state changes on its rising edge.
  reset_l  in  1  asynchronous, active-low reset.
  enable  in  1  high: periodic sampling runs.
  sample_now  in  1  one-cycle pulse; requests an immediate read.
  go  out  1  read request to the I2C magnetometer reader.
  rd_done  in  1  one-cycle pulse from reader; x_data/y_data valid in that cycle.
  x_data  in  16  X field, two's complement.
  y_data  in  16  Y field, two's complement.
  rom_addr  out  8  atan ROM address.
  rom_data  in  8  atan ROM output in degrees (0..90), valid 1 cycle after rom_addr.
  heading  out  10  last heading, degrees 0..359.
  heading_valid  out  1  one-cycle pulse when heading updates.
  busy  out  1  high whenever state is not IDLE.
  timeout_err  out  1  one-cycle pulse on read timeout.

Function
REQ-005 SHALL implement states IDLE, GO, WAIT_RD, LATCH, DIVIDE, ROM_ADDR, ROM_WAIT, OUTPUT.
REQ-006 SHALL run a period counter while enable=1; at SAMPLE_PERIOD-1 it wraps to 0 and sets pending; enable=0 holds counter at 0.
REQ-007 SHALL set pending on sample_now regardless of enable; pending is one-deep, extra requests while pending/busy are merged.
REQ-008 IDLE with pending=1 SHALL go to GO and clear pending that cycle.
REQ-009 GO SHALL drive go=1 for exactly GO_WIDTH cycles, then enter WAIT_RD with go=0.
REQ-010 WAIT_RD SHALL enter LATCH on rd_done=1, registering x_data and y_data; rd_done outside WAIT_RD is ignored.
REQ-011 WAIT_RD SHALL, after RD_TIMEOUT cycles without rd_done, pulse timeout_err and return to IDLE, heading unchanged.
REQ-012 LATCH SHALL compute magnitudes ax=|x|, ay=|y| (15 bit; -32768 saturates to 32767) and quadrant: x>=0,y>=0 ->1; x<0,y>=0 ->2; x<0,y<0 ->3; x>=0,y<0 ->4.
REQ-013 LATCH SHALL set large=max(ax,ay), small=min, y_major=(ay>ax), q=0; if small=0 then q=9.
REQ-014 DIVIDE SHALL perform one step per cycle: if q<9 and remainder>=small, remainder-=small, q+=1; else go to ROM_ADDR; result q=min(floor(large/small),9).
REQ-015 ROM_ADDR SHALL drive rom_addr = 9+q if y_major, else 9-q (ax=ay gives 9); ROM_WAIT waits one cycle; rom_addr holds its value until next computation.
REQ-016 OUTPUT SHALL set heading = a, 180-a, 180+a, 360-a for quadrants 1..4 (a=rom_data), 360 mapped to 0, pulse heading_valid, return to IDLE.
REQ-017 heading_valid SHALL assert no later than 14 cycles after the rd_done cycle.
REQ-018 busy SHALL be 1 in every state except IDLE.

Reset
REQ-019 reset_l=0 SHALL immediately force IDLE, go=0, heading=0, heading_valid=0, timeout_err=0, rom_addr=0, pending=0, period counter=0, in any state including mid-DIVIDE or mid-GO.
REQ-020 After reset release, first automatic read SHALL start SAMPLE_PERIOD cycles after enable is seen high.

Verification (bench ROM model: rom_data=5*rom_addr, 1-cycle latency; SAMPLE_PERIOD=50, GO_WIDTH=4, RD_TIMEOUT=20)
REQ-021 sample_now, rd_done with x=100,y=100 -> go high 4 cycles, rom_addr=9, heading=45, one heading_valid pulse.
REQ-022 x=-300,y=100 -> q=3, rom_addr=6, heading=150.
REQ-023 x=0,y=-200 -> q=9, rom_addr=18, heading=270; x=0,y=0 -> heading=45.
REQ-024 sample_now, no rd_done -> timeout_err pulses 20 cycles after go falls, heading unchanged, busy=0 next cycle.
REQ-025 enable=1 for 200 cycles with reader model replying 3 cycles after go -> go pulses every 50 cycles; sample_now during busy causes exactly one extra read.
REQ-026 reset_l low during DIVIDE -> all outputs to reset values same cycle, no heading_valid after release.
